// File: rtl/alu_exec_unit_pkg.sv
// Shared ALUControl code map and execute-unit FSM encoding, imported by the
// ALU control decoder and the execute unit.
package alu_defs;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_MUL  = 6'b011000;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_NOR  = 6'b100111;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLL  = 6'b000000;
  localparam logic [5:0] ALU_SRL  = 6'b000010;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_JR   = 6'b001000;
  localparam logic [5:0] ALU_BCMP = 6'b000001;
  localparam logic [5:0] ALU_SB   = 6'b101000;
  localparam logic [5:0] ALU_SH   = 6'b101001;
  localparam logic [5:0] ALU_LH   = 6'b100001;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_e;

  // True for every code the execute unit implements, MUL included.
  function automatic logic alu_code_known(input logic [5:0] code);
    logic known;
    case (code)
      ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SLT, ALU_JR, ALU_BCMP, ALU_SB, ALU_SH,
      ALU_LH:  known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the ID/EX stage and the execute unit.
interface alu_exec_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic [5:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       shamt;
  logic             flush;
  logic             ready;
  logic             out_valid;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Neg;
  logic             illegal;

  modport master (
    output in_valid, ALUControl, A, B, shamt, flush,
    input  ready, out_valid, Result, Zero, Neg, illegal
  );

  modport slave (
    input  in_valid, ALUControl, A, B, shamt, flush,
    output ready, out_valid, Result, Zero, Neg, illegal
  );

endinterface

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier: retires MUL_STEP_BITS multiplier bits per
// cycle and flags the final step so the caller can register the product.
module iter_multiplier #(
  parameter int WIDTH         = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int STEPS = WIDTH / MUL_STEP_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] partial_s;
  logic             busy_s;

  assign busy_s = (cnt_q != CNT_ZERO);

  // Partial product of the multiplicand with the low multiplier bits.
  always_comb begin
    partial_s = {WIDTH{1'b0}};
    for (int k = 0; k < MUL_STEP_BITS; k++) begin
      if (mplier_q[k]) begin
        partial_s = partial_s + (mcand_q << k);
      end else begin
        partial_s = partial_s;
      end
    end
  end

  // Load, step or abandon the multiply.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (abort_i) begin
      cnt_d = CNT_ZERO;
    end else if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = {WIDTH{1'b0}};
      cnt_d    = CNT_LOAD;
    end else if (busy_s) begin
      acc_d    = acc_q + partial_s;
      mcand_d  = mcand_q << MUL_STEP_BITS;
      mplier_d = mplier_q >> MUL_STEP_BITS;
      cnt_d    = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= CNT_ZERO;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // The last step's sum is offered directly so the product lands on the same edge.
  assign done_o    = busy_s && (cnt_q == CNT_ONE);
  assign product_o = acc_q + partial_s;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops register in one edge, MUL stalls issue
// via ready while the iterative multiplier runs.
module alu_exec_unit
  import alu_defs::*;
#(
  parameter int WIDTH         = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  alu_exec_if.slave  bus
);

  alu_state_e       state_q, state_d;
  logic             ready_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             mul_start_s;
  logic             mul_abort_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_product_s;
  logic [WIDTH-1:0] sc_result_s;
  logic             sc_illegal_s;
  logic             load_s;
  logic [WIDTH-1:0] load_result_s;
  logic             load_illegal_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             illegal_q, illegal_d;

  assign accept_s    = bus.in_valid && ready_s;
  assign is_mul_s    = (bus.ALUControl == ALU_MUL);
  assign mul_start_s = accept_s && is_mul_s && !bus.flush;
  assign mul_abort_s = (state_q == ST_MUL_BUSY) && bus.flush;

  iter_multiplier #(
    .WIDTH         (WIDTH),
    .MUL_STEP_BITS (MUL_STEP_BITS)
  ) u_mul (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .start_i   (mul_start_s),
    .abort_i   (mul_abort_s),
    .a_i       (bus.A),
    .b_i       (bus.B),
    .done_o    (mul_done_s),
    .product_o (mul_product_s)
  );

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush beats completion in MUL_BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_start_s) state_d = ST_MUL_BUSY;
        else             state_d = ST_IDLE;
      end
      ST_MUL_BUSY: begin
        if (bus.flush || mul_done_s) state_d = ST_IDLE;
        else                         state_d = ST_MUL_BUSY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_IDLE:     ready_s = 1'b1;
      ST_MUL_BUSY: ready_s = 1'b0;
      default:     ready_s = 1'b0;
    endcase
  end

  // Single-cycle operation datapath.
  always_comb begin
    sc_result_s  = {WIDTH{1'b0}};
    sc_illegal_s = !alu_code_known(bus.ALUControl);
    case (bus.ALUControl)
      ALU_ADD, ALU_SB, ALU_SH, ALU_LH: sc_result_s = bus.A + bus.B;
      ALU_SUB, ALU_BCMP:               sc_result_s = bus.A - bus.B;
      ALU_AND:  sc_result_s = bus.A & bus.B;
      ALU_OR:   sc_result_s = bus.A | bus.B;
      ALU_NOR:  sc_result_s = ~(bus.A | bus.B);
      ALU_XOR:  sc_result_s = bus.A ^ bus.B;
      ALU_SLL:  sc_result_s = bus.B << bus.shamt;
      ALU_SRL:  sc_result_s = bus.B >> bus.shamt;
      ALU_SLT: begin
        if ($signed(bus.A) < $signed(bus.B)) sc_result_s = {{(WIDTH-1){1'b0}}, 1'b1};
        else                                 sc_result_s = {WIDTH{1'b0}};
      end
      ALU_JR:   sc_result_s = bus.A;
      default:  sc_result_s = {WIDTH{1'b0}};
    endcase
  end

  // Pick what, if anything, lands in the output registers this edge.
  always_comb begin
    load_s         = 1'b0;
    load_result_s  = sc_result_s;
    load_illegal_s = sc_illegal_s;
    if (state_q == ST_MUL_BUSY) begin
      load_s         = mul_done_s && !bus.flush;
      load_result_s  = mul_product_s;
      load_illegal_s = 1'b0;
    end else if (accept_s && !is_mul_s && !bus.flush) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Result and flags hold whenever nothing completes.
  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    illegal_d   = illegal_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      result_d    = load_result_s;
      zero_d      = (load_result_s == {WIDTH{1'b0}});
      neg_d       = load_result_s[WIDTH-1];
      illegal_d   = load_illegal_s;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // EX/MEM output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.ready     = ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Zero      = zero_q;
  assign bus.Neg       = neg_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 6-bit ALUControl code from the ALU control decoder and produces a registered result and flags for the EX/MEM boundary.
- Single-cycle operations complete with 1-cycle latency.
- MUL runs on an iterative shift-add multiplier and stalls the pipeline until it finishes.
- Branch-compare and address codes produce flags and effective addresses for the branch and memory stages.

Parameters:
- WIDTH, 32, datapath width. The codebase instantiates only 32.
- MUL_STEP_BITS, 1, multiplier bits retired per cycle. Must divide WIDTH. MUL takes WIDTH/MUL_STEP_BITS cycles.

Ports:
- Clk  in  1  system clock; all logic is rising-edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and code are presented this cycle.
- ALUControl  in  6  operation code from the ALU control decoder.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand or sign-extended immediate.
- shamt  in  5  shift amount.
- flush  in  1  cancels the operation in flight.
- ready  out  1  the unit can accept in_valid this cycle.
- out_valid  out  1  Result and flags are valid; pulses for 1 cycle.
- Result  out  WIDTH  registered result.
- Zero  out  1  Result == 0.
- Neg  out  1  Result[WIDTH-1].
- illegal  out  1  the accepted code was unrecognised.

Behaviour:
- Reset: the FSM goes to IDLE. ready=1. out_valid, Result, Zero, Neg and illegal are all 0. Reset mid-MUL abandons the multiply with no output.
- FSM states are IDLE and MUL_BUSY.
- Accept rule: an operation is accepted when in_valid && ready. ready = (state==IDLE). in_valid while busy is ignored; upstream holds its stage on !ready.
- Single-cycle codes are accepted in IDLE. On the next edge, Result and flags are registered, out_valid=1 for 1 cycle, and the state stays IDLE. Back-to-back issue gives one result per cycle.
- Code map, with 32-bit wrap arithmetic and no overflow trap:
  - 100000 A+B.
  - 100010 A-B.
  - 100100 A&B.
  - 100101 A|B.
  - 100111 ~(A|B).
  - 100110 A^B.
  - 000000 B<<shamt.
  - 000010 B>>shamt, logical.
  - 101010 signed(A)<signed(B) ? 1 : 0.
  - 001000 (jr) passes A.
  - 000001 (branch compare) A-B; consumers read Zero and Neg.
  - 101000/101001/100001 (sb/sh/lh address) A+B.
- MUL (011000) latches A and B, clears the accumulator, loads the counter with WIDTH/MUL_STEP_BITS and enters MUL_BUSY. ready=0 from the cycle after accept.
- Each MUL_BUSY cycle adds the partial product of the low MUL_STEP_BITS of the multiplier into the accumulator, shifts, and decrements the counter.
- When the counter reaches 0, Result is the low WIDTH bits of A*B (sign-agnostic), out_valid=1, and the state returns to IDLE. ready=1 in that same cycle.
- MUL latency is accept edge + 32 cycles at default, so out_valid appears 33 edges after accept.
- Unrecognised code: Result=0, Zero=1, Neg=0, illegal=1 and out_valid=1 for 1 cycle.
- flush in IDLE suppresses out_valid for an operation accepted in the same cycle.
- flush in MUL_BUSY returns to IDLE next edge with no out_valid, and Result holds its previous value.
- flush together with completion: flush wins and out_valid stays 0.
- Result, Zero, Neg and illegal hold their values while out_valid=0.

Decomposition:
- Shared package alu_defs holds:
  - localparams for every ALUControl code (ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT, ALU_JR, ALU_BCMP, ALU_SB, ALU_SH, ALU_LH);
  - the FSM state encoding.
- The ALU control decoder imports the same package.
- One sub-module, iter_multiplier, owns the counter, shift-add datapath and done pulse.

Test Plan:
- Reset asserted for 2 cycles mid-MUL → ready=1, out_valid=0 and Result=0 the cycle after release; no late out_valid.
- Back-to-back issue: ADD A=7,B=5, then SUB A=3,B=5, then SLT A=0xFFFFFFFF,B=1 on consecutive cycles → Result sequence 12, 0xFFFFFFFE (Neg=1), 1; out_valid high for 3 consecutive cycles.
- Shifts: SLL B=1,shamt=31 → 0x80000000. SRL B=0x80000000,shamt=4 → 0x08000000.
- MUL A=0xFFFFFFFF,B=3 → ready low for 32 cycles, then Result=0xFFFFFFFD with one out_valid pulse 33 edges after accept. in_valid ADD during busy is ignored.
- Branch compare A=B=0x1234 → Zero=1, Neg=0. Unknown code 111111 → illegal=1, Result=0.
- flush at cycle 10 of a MUL → no out_valid, ready=1 next cycle, and a new ADD completes normally.
